crypto_mm_wrapper: RTL and testbench

CRYPTO_MM_WRAPPER -- requirements
Module: crypto_mm_wrapper

---
 rtl/crypto_mm_pkg.sv | 30 +++
 rtl/crypto_mm_timer.sv | 39 +++
 rtl/crypto_mm_wrapper.sv | 209 ++++++++++++++++++++
 tb/tb_crypto_mm_wrapper.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/crypto_mm_pkg.sv
// Shared definitions for the crypto core memory-mapped wrapper: register offsets,
// CTRL/STATUS bit positions and the sequencer state encoding.
package crypto_mm_pkg;

  // Byte offsets within the 4 KB region
  localparam logic [11:0] OffCtrl    = 12'h000;
  localparam logic [11:0] OffStatus  = 12'h004;
  // IN words live at 0x100+4i, RESULT words at 0x800+4i; decoded by offset[11:8]
  localparam logic [3:0]  PageIn     = 4'h1;
  localparam logic [3:0]  PageResult = 4'h8;

  // CTRL bits
  localparam int unsigned CtrlStartBit = 0;
  localparam int unsigned CtrlAbortBit = 1;
  localparam int unsigned CtrlIrqEnBit = 2;

  // STATUS bits
  localparam int unsigned StatusDoneBit    = 0;
  localparam int unsigned StatusBusyBit    = 1;
  localparam int unsigned StatusWerrBit    = 2;
  localparam int unsigned StatusTimeoutBit = 3;
  localparam int unsigned StatusIrqEnBit   = 4;

  typedef enum logic [1:0] {
    StIdle,
    StLaunch,
    StRun
  } state_e;

endpackage

// File: rtl/crypto_mm_timer.sv
// RUN-phase watchdog counter. Cleared while launching, counts each RUN cycle and
// flags expiry on the RUN cycle that reaches TIMEOUT_CYCLES.
module crypto_mm_timer
  import crypto_mm_pkg::*;
#(
  parameter logic [31:0] TIMEOUT_CYCLES = 32'd65535
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  logic [31:0] cnt_q, cnt_d;

  // Next count: clear on launch, advance while running
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + 32'd1;
    end
  end

  // cnt_q holds the number of RUN cycles already completed
  assign expired_o = en_i && ((cnt_q + 32'd1) >= TIMEOUT_CYCLES);

  // Counter register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/crypto_mm_wrapper.sv
// Memory-mapped wrapper around a crypto core: operand/result registers, CTRL/STATUS,
// and an IDLE/LAUNCH/RUN sequencer. Define CRYPTO_MM_TIMEOUT_EN to build the RUN
// timeout (crypto_mm_timer); otherwise TIMEOUT always reads 0.
module crypto_mm_wrapper
  import crypto_mm_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR      = 32'h4000_4000,
  parameter int unsigned IN_WORDS       = 8,
  parameter int unsigned OUT_WORDS      = 8,
  parameter logic [31:0] TIMEOUT_CYCLES = 32'd65535
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [31:0]             addr,
  input  logic [31:0]             wdata,
  input  logic                    we,
  input  logic                    valid,
  output logic [31:0]             rdata,
  output logic                    ready,
  output logic                    core_start,
  output logic [32*IN_WORDS-1:0]  core_in,
  input  logic                    core_done,
  input  logic [32*OUT_WORDS-1:0] core_out,
  output logic                    irq
);

  state_e      state_q, state_d;
  logic        done_q, done_d, werr_q, werr_d, timeout_q, timeout_d;
  logic        irq_en_q, irq_en_d, irq_q, irq_d, ready_q;
  logic [31:0] rdata_q, rdata_d;
  logic [31:0] in_q  [IN_WORDS];
  logic [31:0] in_d  [IN_WORDS];
  logic [31:0] res_q [OUT_WORDS];
  logic [31:0] res_d [OUT_WORDS];

  logic        sel, wr_en, rd_en, ctrl_wr, status_rd, start_req, abort_req;
  logic        busy, in_page, res_page, timer_expired;
  logic [11:0] off;
  logic [5:0]  word_idx;
  logic [31:0] status_vec;

  assign sel       = valid && (addr[31:12] == BASE_ADDR[31:12]);
  assign wr_en     = sel && we;
  assign rd_en     = sel && !we;
  assign off       = addr[11:0];
  assign word_idx  = addr[7:2];
  assign in_page   = (off[11:8] == PageIn);
  assign res_page  = (off[11:8] == PageResult);
  assign ctrl_wr   = wr_en && (off == OffCtrl);
  assign status_rd = rd_en && (off == OffStatus);
  assign start_req = ctrl_wr && wdata[CtrlStartBit];
  assign abort_req = ctrl_wr && wdata[CtrlAbortBit];
  assign busy      = (state_q != StIdle);

`ifdef CRYPTO_MM_TIMEOUT_EN
  crypto_mm_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr_i    (state_q == StLaunch),
    .en_i     (state_q == StRun),
    .expired_o(timer_expired)
  );
`else
  logic unused_timeout_cycles;
  assign unused_timeout_cycles = ^TIMEOUT_CYCLES;
  assign timer_expired = 1'b0;
`endif

  // Sequencer, status flags and register-file updates
  always_comb begin
    state_d   = state_q;
    done_d    = done_q;
    werr_d    = werr_q;
    timeout_d = timeout_q;
    irq_en_d  = irq_en_q;
    in_d      = in_q;
    res_d     = res_q;

    // Read-to-clear first so any set below in the same cycle wins
    if (status_rd) begin
      done_d    = 1'b0;
      werr_d    = 1'b0;
      timeout_d = 1'b0;
    end

    if (ctrl_wr) begin
      irq_en_d = wdata[CtrlIrqEnBit];
    end

    // Operand writes are rejected while the core may be reading them
    for (int unsigned i = 0; i < IN_WORDS; i++) begin
      if (wr_en && in_page && (word_idx == 6'(i))) begin
        if (busy) begin
          werr_d = 1'b1;
        end else begin
          in_d[i] = wdata;
        end
      end
    end

    unique case (state_q)
      StIdle: begin
        if (start_req) begin
          state_d   = StLaunch;
          done_d    = 1'b0;
          werr_d    = 1'b0;
          timeout_d = 1'b0;
        end
      end
      StLaunch: begin
        state_d = StRun;
      end
      StRun: begin
        // Completion beats both abort and timeout
        if (core_done) begin
          for (int unsigned i = 0; i < OUT_WORDS; i++) begin
            res_d[i] = core_out[32*i +: 32];
          end
          done_d  = 1'b1;
          state_d = StIdle;
        end else if (abort_req) begin
          state_d = StIdle;
        end else if (timer_expired) begin
          timeout_d = 1'b1;
          state_d   = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    irq_d = irq_en_d && (done_d || timeout_d);
  end

  // Read data mux; returns pre-update register values
  always_comb begin
    status_vec                   = '0;
    status_vec[StatusDoneBit]    = done_q;
    status_vec[StatusBusyBit]    = busy;
    status_vec[StatusWerrBit]    = werr_q;
    status_vec[StatusTimeoutBit] = timeout_q;
    status_vec[StatusIrqEnBit]   = irq_en_q;

    rdata_d = '0;
    if (rd_en) begin
      if (off == OffStatus) begin
        rdata_d = status_vec;
      end
      for (int unsigned i = 0; i < IN_WORDS; i++) begin
        if (in_page && (word_idx == 6'(i))) begin
          rdata_d = in_q[i];
        end
      end
      for (int unsigned i = 0; i < OUT_WORDS; i++) begin
        if (res_page && (word_idx == 6'(i))) begin
          rdata_d = res_q[i];
        end
      end
    end
  end

  // Operands go to the core straight from the IN registers
  always_comb begin
    core_in = '0;
    for (int unsigned i = 0; i < IN_WORDS; i++) begin
      core_in[32*i +: 32] = in_q[i];
    end
  end

  // State and register storage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      done_q    <= 1'b0;
      werr_q    <= 1'b0;
      timeout_q <= 1'b0;
      irq_en_q  <= 1'b0;
      irq_q     <= 1'b0;
      ready_q   <= 1'b0;
      rdata_q   <= '0;
      for (int unsigned i = 0; i < IN_WORDS; i++) begin
        in_q[i] <= '0;
      end
      for (int unsigned i = 0; i < OUT_WORDS; i++) begin
        res_q[i] <= '0;
      end
    end else begin
      state_q   <= state_d;
      done_q    <= done_d;
      werr_q    <= werr_d;
      timeout_q <= timeout_d;
      irq_en_q  <= irq_en_d;
      irq_q     <= irq_d;
      ready_q   <= sel;
      rdata_q   <= rdata_d;
      in_q      <= in_d;
      res_q     <= res_d;
    end
  end

  assign rdata      = rdata_q;
  assign ready      = ready_q;
  assign irq        = irq_q;
  assign core_start = (state_q == StLaunch);

endmodule

// File: tb/tb_crypto_mm_wrapper.sv
// Directed-plus-random bench for crypto_mm_wrapper with a register-map level model.
module tb_crypto_mm_wrapper;

  localparam int unsigned   NW   = 4;
  localparam logic [31:0]   BASE = 32'h4000_4000;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [31:0]       addr = '0, wdata = '0;
  logic              we = 1'b0, valid = 1'b0, core_done = 1'b0;
  logic [32*NW-1:0]  core_out = '0;
  logic [31:0]       rdata;
  logic              ready, core_start, irq;
  logic [32*NW-1:0]  core_in;

  crypto_mm_wrapper #(
    .BASE_ADDR     (BASE),
    .IN_WORDS      (NW),
    .OUT_WORDS     (NW),
    .TIMEOUT_CYCLES(32'd20)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .addr      (addr),
    .wdata     (wdata),
    .we        (we),
    .valid     (valid),
    .rdata     (rdata),
    .ready     (ready),
    .core_start(core_start),
    .core_in   (core_in),
    .core_done (core_done),
    .core_out  (core_out),
    .irq       (irq)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model state
  logic [31:0] m_in  [NW];
  logic [31:0] m_res [NW];
  logic        m_done, m_werr, m_timeout, m_irq_en, m_busy;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] m_status();
    return {27'b0, m_irq_en, m_timeout, m_werr, m_busy, m_done};
  endfunction

  function automatic logic [127:0] m_core_in();
    logic [127:0] r;
    r = '0;
    for (int i = 0; i < NW; i++) r[32*i +: 32] = m_in[i];
    return r;
  endfunction

  function automatic logic [127:0] rand_words();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NW; i++) begin
      m_in[i]  = '0;
      m_res[i] = '0;
    end
    m_done = 0; m_werr = 0; m_timeout = 0; m_irq_en = 0; m_busy = 0;
  endtask

  task automatic capture(input logic [127:0] co);
    for (int i = 0; i < NW; i++) m_res[i] = co[32*i +: 32];
    m_done = 1;
    m_busy = 0;
  endtask

  // One bus access, optionally with core_done in the same cycle
  task automatic bus(input logic [31:0] a, input logic w, input logic [31:0] d,
                     input logic cd, input logic [127:0] co, input string tag);
    logic        hit, pre_busy;
    logic [31:0] exp_rd;
    int          o;
    hit      = (a[31:12] == BASE[31:12]);
    o        = int'(a[11:0]);
    exp_rd   = '0;
    pre_busy = m_busy;
    @(negedge clk);
    addr = a; we = w; wdata = d; valid = 1'b1; core_done = cd; core_out = co;
    @(posedge clk);
    #1;
    valid = 1'b0; we = 1'b0; core_done = 1'b0;
    if (hit && !w) begin
      if (o == 4) begin
        exp_rd = m_status();
        m_done = 0; m_werr = 0; m_timeout = 0;
      end else if (o >= 'h100 && o < 'h100 + 4 * NW) begin
        exp_rd = m_in[(o - 'h100) / 4];
      end else if (o >= 'h800 && o < 'h800 + 4 * NW) begin
        exp_rd = m_res[(o - 'h800) / 4];
      end
    end
    if (hit && w) begin
      if (o == 0) begin
        m_irq_en = d[2];
        if (d[0] && !pre_busy) begin
          m_busy = 1; m_done = 0; m_werr = 0; m_timeout = 0;
        end else if (d[1] && pre_busy && !cd) begin
          m_busy = 0;
        end
      end else if (o >= 'h100 && o < 'h100 + 4 * NW) begin
        if (pre_busy) m_werr = 1;
        else m_in[(o - 'h100) / 4] = d;
      end
    end
    if (cd && pre_busy) capture(co);
    chk({tag, "_ready"}, ready, hit);
    if (hit && !w) chk({tag, "_rdata"}, rdata, exp_rd);
    chk({tag, "_irq"}, irq, m_irq_en & (m_done | m_timeout));
  endtask

  task automatic pulse_done(input logic [127:0] co, input string tag);
    @(negedge clk);
    core_done = 1'b1; core_out = co;
    @(posedge clk);
    #1;
    core_done = 1'b0;
    if (m_busy) capture(co);
    chk({tag, "_irq"}, irq, m_irq_en & (m_done | m_timeout));
  endtask

  // Bounded wait for the launch pulse, then confirm it lasts one cycle
  task automatic wait_start(input string tag);
    for (int i = 0; i < 6 && core_start !== 1'b1; i++) begin
      @(posedge clk);
      #1;
    end
    chk({tag, "_start"}, core_start, 1'b1);
    @(posedge clk);
    #1;
    chk({tag, "_start_1cyc"}, core_start, 1'b0);
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic read_results(input string tag);
    for (int i = 0; i < NW; i++) bus(BASE + 32'h800 + 4 * i, 0, 0, 0, '0, tag);
  endtask

  task automatic write_ins(input logic [127:0] v, input string tag);
    for (int i = 0; i < NW; i++) bus(BASE + 32'h100 + 4 * i, 1, v[32*i +: 32], 0, '0, tag);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] co;
    model_reset();

    // Reset values
    cycles(2);
    chk("rst_rdata", rdata, 0);
    chk("rst_ready", ready, 0);
    chk("rst_start", core_start, 0);
    chk("rst_irq", irq, 0);
    chk("rst_core_in", core_in, 0);
    @(negedge clk);
    rst_n = 1'b1;
    bus(BASE + 32'h004, 0, 0, 0, '0, "rst_status");
    bus(BASE + 32'h100, 0, 0, 0, '0, "rst_in0");
    bus(BASE + 32'h800, 0, 0, 0, '0, "rst_res0");

    // Nominal run
    write_ins({32'd4, 32'd3, 32'd2, 32'd1}, "nom_win");
    bus(BASE + 32'h108, 0, 0, 0, '0, "nom_rin2");
    chk("nom_core_in", core_in, m_core_in());
    bus(BASE, 1, 32'h1, 0, '0, "nom_go");
    wait_start("nom");
    cycles(9);
    co = {$urandom, $urandom, $urandom, 32'hDEAD_BEEF};
    pulse_done(co, "nom_done");
    bus(BASE + 32'h004, 0, 0, 0, '0, "nom_status1");
    cycles(1);
    chk("nom_ready_drop", ready, 0);
    read_results("nom_res");
    bus(BASE + 32'h004, 0, 0, 0, '0, "nom_status2");

    // Operand write while busy
    write_ins(rand_words(), "bw_win");
    bus(BASE, 1, 32'h1, 0, '0, "bw_go");
    wait_start("bw");
    bus(BASE + 32'h108, 1, 32'hFFFF_FFFF, 0, '0, "bw_w2");
    chk("bw_core_in", core_in, m_core_in());
    bus(BASE + 32'h004, 0, 0, 0, '0, "bw_status_run");
    pulse_done(rand_words(), "bw_done");
    read_results("bw_res");
    bus(BASE + 32'h004, 0, 0, 0, '0, "bw_status_end");

    // STATUS read coinciding with completion: set wins
    bus(BASE, 1, 32'h1, 0, '0, "rc_go");
    wait_start("rc");
    bus(BASE + 32'h004, 0, 0, 1, rand_words(), "rc_rd_done");
    bus(BASE + 32'h004, 0, 0, 0, '0, "rc_status");

    // Abort together with core_done: done wins
    bus(BASE, 1, 32'h1, 0, '0, "ac_go");
    wait_start("ac");
    cycles(3);
    bus(BASE, 1, 32'h2, 1, rand_words(), "ac_abort_done");
    read_results("ac_res");
    bus(BASE + 32'h004, 0, 0, 0, '0, "ac_status");

    // Abort alone, then a stray core_done in IDLE
    bus(BASE, 1, 32'h1, 0, '0, "ab_go");
    wait_start("ab");
    bus(BASE, 1, 32'h2, 0, '0, "ab_abort");
    bus(BASE + 32'h004, 0, 0, 0, '0, "ab_status");
    pulse_done(rand_words(), "ab_stray");
    bus(BASE + 32'h800, 0, 0, 0, '0, "ab_res0");
    bus(BASE + 32'h004, 0, 0, 0, '0, "ab_status2");

    // Timeout with IRQ enabled
    bus(BASE, 1, 32'h5, 0, '0, "to_go");
    wait_start("to");
    cycles(24);
`ifdef CRYPTO_MM_TIMEOUT_EN
    m_timeout = 1;
    m_busy    = 0;
    chk("to_irq", irq, 1'b1);
    bus(BASE + 32'h004, 0, 0, 0, '0, "to_status");
`else
    chk("to_irq", irq, 1'b0);
    bus(BASE + 32'h004, 0, 0, 0, '0, "to_status");
    bus(BASE, 1, 32'h2, 0, '0, "to_abort");
`endif
    bus(BASE, 1, 32'h0, 0, '0, "to_irq_off");
    bus(BASE + 32'h004, 0, 0, 0, '0, "to_status_end");

    // Reset in RUN
    bus(BASE, 1, 32'h5, 0, '0, "rr_go");
    wait_start("rr");
    cycles(3);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("rr_rdata", rdata, 0);
    chk("rr_ready", ready, 0);
    chk("rr_start", core_start, 0);
    chk("rr_irq", irq, 0);
    chk("rr_core_in", core_in, 0);
    @(negedge clk);
    rst_n = 1'b1;
    pulse_done(rand_words(), "rr_stray");
    for (int i = 0; i < 5; i++) begin
      chk("rr_no_start", core_start, 0);
      cycles(1);
    end
    bus(BASE + 32'h004, 0, 0, 0, '0, "rr_status");
    bus(BASE + 32'h800, 0, 0, 0, '0, "rr_res0");

    // Region select and unmapped offsets
    bus(32'h4000_5000, 0, 0, 0, '0, "rg_other");
    bus(32'h4000_5100, 1, 32'hAAAA_5555, 0, '0, "rg_other_w");
    bus(BASE + 32'h100, 0, 0, 0, '0, "rg_in0");
    bus(BASE + 32'h7FC, 0, 0, 0, '0, "rg_7fc");
    bus(BASE + 32'h110, 0, 0, 0, '0, "rg_in_oob");
    bus(BASE + 32'h000, 0, 0, 0, '0, "rg_ctrl_rd");
    bus(BASE + 32'h800, 1, 32'h1234_5678, 0, '0, "rg_res_w");
    bus(BASE + 32'h800, 0, 0, 0, '0, "rg_res0");

    // Random operations
    for (int n = 0; n < 4; n++) begin
      write_ins(rand_words(), "rnd_win");
      bus(BASE + 32'h100 + 4 * $urandom_range(0, NW - 1), 0, 0, 0, '0, "rnd_rin");
      chk("rnd_core_in", core_in, m_core_in());
      bus(BASE, 1, 32'h1 | ($urandom_range(0, 1) << 2), 0, '0, "rnd_go");
      wait_start("rnd");
      cycles($urandom_range(1, 8));
      pulse_done(rand_words(), "rnd_done");
      bus(BASE + 32'h004, 0, 0, 0, '0, "rnd_status");
      read_results("rnd_res");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
